// File: rtl/bch_pkg.sv
// bch_pkg: shared BCH(63,51) t=2 constants and encoder state type.
package bch_pkg;
  localparam int BCH_N = 63;
  localparam int BCH_K = 51;
  localparam int BCH_PAR = 12;
  localparam logic [6:0] GF_POLY = 7'b1000011;
  localparam logic [12:0] BCH_GEN = 13'h1539;
  localparam logic [12:0] BCH_GEN_REV = 13'h1395;
  typedef enum logic {ST_MSG, ST_PARITY} t_bch_enc_state;
endpackage

// File: rtl/bch_encoder_if.sv
// bch_encoder_if: 1-bit valid/ready input and output streams of the encoder.
interface bch_encoder_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_last;
  logic out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/bch_parity_lfsr.sv
// bch_parity_lfsr: divides the message by the reciprocal generator, then shifts the remainder out MSB first.
module bch_parity_lfsr
  import bch_pkg::*;
#(
  parameter int PAR_LEN = BCH_PAR,
  parameter logic [PAR_LEN:0] POLY = BCH_GEN_REV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load_bit,
  input  logic i_shift_out,
  input  logic i_bit,
  output logic o_msb
);
  logic [PAR_LEN-1:0] r_lfsr;
  logic w_fb;
  assign w_fb = i_bit ^ r_lfsr[PAR_LEN-1];
  assign o_msb = r_lfsr[PAR_LEN-1];
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= '0;
    else if (i_load_bit) r_lfsr <= {r_lfsr[PAR_LEN-2:0], 1'b0} ^ (w_fb ? POLY[PAR_LEN-1:0] : '0);
    else if (i_shift_out) r_lfsr <= {r_lfsr[PAR_LEN-2:0], 1'b0};
  end
endmodule

// File: rtl/bch_encoder.sv
// bch_encoder: bit-serial systematic BCH(63,51) encoder, message bits first then 12 parity bits.
module bch_encoder
  import bch_pkg::*;
#(
  parameter int MSG_LEN = BCH_K,
  parameter int PAR_LEN = BCH_PAR,
  parameter logic [PAR_LEN:0] GEN_POLY = BCH_GEN_REV
) (
  input logic clk,
  input logic rst,
  bch_encoder_if.slave bus
);
  localparam logic [5:0] LAST_MSG = 6'(MSG_LEN - 1);
  localparam logic [5:0] LAST_BIT = 6'(MSG_LEN + PAR_LEN - 1);
  t_bch_enc_state r_state, w_state_nxt;
  logic [5:0] r_bit_cnt, w_cnt_nxt;
  logic r_out_valid, r_out_data, r_out_last;
  logic w_load, w_in_ready, w_in_xfer, w_par_load, w_lfsr_msb;
  // The output stage can take a new bit when empty or draining this cycle.
  assign w_load = !r_out_valid | bus.out_ready;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_bit_cnt;
    w_in_ready = 1'b0;
    w_in_xfer = 1'b0;
    w_par_load = 1'b0;
    if (r_state == ST_MSG) begin
      w_in_ready = w_load & !rst;
      w_in_xfer = w_in_ready & bus.in_valid;
      w_cnt_nxt = w_in_xfer ? r_bit_cnt + 6'd1 : r_bit_cnt;
      w_state_nxt = (w_in_xfer && r_bit_cnt == LAST_MSG) ? ST_PARITY : ST_MSG;
    end else begin
      w_par_load = w_load;
      w_cnt_nxt = !w_load ? r_bit_cnt : (r_bit_cnt == LAST_BIT) ? 6'd0 : r_bit_cnt + 6'd1;
      w_state_nxt = (w_load && r_bit_cnt == LAST_BIT) ? ST_MSG : ST_PARITY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MSG;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= w_in_xfer | w_par_load;
      r_out_last <= w_par_load & (r_bit_cnt == LAST_BIT);
      if (w_in_xfer) r_out_data <= bus.in_data;
      else if (w_par_load) r_out_data <= w_lfsr_msb;
    end
  end
  bch_parity_lfsr #(.PAR_LEN(PAR_LEN), .POLY(GEN_POLY)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .i_load_bit(w_in_xfer),
    .i_shift_out(w_par_load),
    .i_bit(bus.in_data),
    .o_msb(w_lfsr_msb)
  );
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_last = r_out_last;
endmodule

// File: tb/tb_bch_encoder.sv
// tb_bch_encoder: random frames checked against a polynomial-division model and GF(64) syndromes.
module tb_bch_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bch_encoder_if bus ();
  bch_encoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int vld_pct = 100, rdy_pct = 100;
  int ir_low, idle, nout, acc, fpos;
  bit started, hold_pending, held;
  bit msgq[$], expq[$], lastq[$];
  bit frame [0:62];
  logic [11:0] last_par;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p = '0, x = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p ^= x;
      x = {x[4:0], 1'b0} ^ (x[5] ? 6'h03 : 6'h00);
    end
    return p;
  endfunction
  // Expected codeword: x^12*m*(x) mod g*(x) by long division, first bit = highest degree.
  task automatic push_frame(input bit [50:0] m);
    bit [62:0] d = '0;
    bit [12:0] g = 13'h1395;
    for (int k = 0; k < 51; k++) d[62-k] = m[k];
    for (int deg = 62; deg >= 12; deg--)
      if (d[deg]) for (int j = 0; j <= 12; j++) d[deg-12+j] ^= g[j];
    for (int k = 0; k < 63; k++) begin
      if (k < 51) msgq.push_back(m[k]);
      expq.push_back(k < 51 ? m[k] : d[62-k]);
      lastq.push_back(k == 62);
    end
  endtask
  task automatic check_frame();
    logic [5:0] s1 = '0, s3 = '0, a1 = 6'h01, a3 = 6'h01;
    for (int k = 0; k < 63; k++) begin
      if (frame[k]) begin
        s1 ^= a1;
        s3 ^= a3;
      end
      a1 = gmul(a1, 6'h02);
      a3 = gmul(a3, 6'h08);
      if (k >= 51) last_par = {last_par[10:0], frame[k]};
    end
    chk("s1", 32'(s1), 0);
    chk("s3", 32'(s3), 0);
  endtask
  task automatic step();
    @(negedge clk);
    bus.in_valid = msgq.size() > 0 && $urandom_range(99) < vld_pct;
    bus.in_data = bus.in_valid ? msgq[0] : 1'b0;
    bus.out_ready = $urandom_range(99) < rdy_pct;
    #1;
    if (hold_pending) chk("hold", {bus.out_valid, bus.out_data}, {1'b1, held});
    if (!bus.in_ready) ir_low++;
    if (bus.out_valid) started = 1;
    else if (started && expq.size() > 0) idle++;
    if (bus.out_valid && bus.out_ready) begin
      nout++;
      if (expq.size() == 0) chk("extra_out", 1, 0);
      else begin
        chk("bit", bus.out_data, expq.pop_front());
        chk("last", bus.out_last, lastq.pop_front());
        frame[fpos] = bus.out_data;
        if (bus.out_last) begin
          chk("flen", fpos, 62);
          check_frame();
          fpos = 0;
        end else fpos = (fpos + 1) % 63;
      end
    end
    hold_pending = bus.out_valid && !bus.out_ready;
    held = bus.out_data;
    if (bus.in_valid && bus.in_ready) begin
      void'(msgq.pop_front());
      acc++;
    end
  endtask
  task automatic drain(input int budget);
    for (int n = 0; n < budget && (msgq.size() > 0 || expq.size() > 0); n++) step();
    chk("drained", expq.size(), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    msgq.delete();
    expq.delete();
    lastq.delete();
    fpos = 0;
    hold_pending = 0;
    started = 0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    rst = 1'b0;
  endtask
  function automatic bit [50:0] rnd_msg();
    return {$urandom(), $urandom()};
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b0;
    fpos = 0;
    do_reset();
    ir_low = 0; idle = 0; started = 0;
    push_frame('0);
    drain(200);
    chk("ir_low_cycles", ir_low, 12);
    chk("zero_idle", idle, 0);
    push_frame(51'b1 << 50);
    drain(200);
    chk("par_onehot", last_par, 12'h395);
    idle = 0; nout = 0; acc = 0; started = 0;
    for (int f = 0; f < 60; f++) push_frame(rnd_msg());
    drain(5000);
    chk("b2b_idle", idle, 0);
    chk("b2b_out", nout, 60 * 63);
    chk("b2b_in", acc, 60 * 51);
    push_frame(rnd_msg());
    acc = 0;
    for (int n = 0; n < 1000 && acc < 30; n++) step();
    chk("mid_acc", acc, 30);
    do_reset();
    push_frame(rnd_msg());
    drain(200);
    vld_pct = 60;
    rdy_pct = 50;
    for (int f = 0; f < 139; f++) push_frame(rnd_msg());
    drain(60000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
